// File: rtl/uart_cmd_frame_tx.sv
// UART command-frame transmitter: buffers a payload, then sends head, type, len, payload
// into the Uart_Drive user TX handshake. Define UART_CMD_CSUM_EN to append a mod-256 checksum byte.

module uart_cmd_frame_tx #(
   parameter int         P_MAX_LEN = 16,
   parameter logic [7:0] P_HEAD    = 8'h55,
   localparam int        LW        = $clog2(P_MAX_LEN + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [7:0]    i_cmd_type,
   input  logic [LW-1:0] i_cmd_len,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic [7:0]    i_pld_data,
   input  logic          i_pld_valid,
   output logic          o_pld_ready,
   output logic [7:0]    o_tx_data,
   output logic          o_tx_valid,
   input  logic          i_tx_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   // Every handshake (cmd, pld, tx) transfers on a rising edge where valid and ready are both 1;
   // a source holds its data stable until that edge, and ready never depends combinationally on valid.

   localparam int IW    = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
   localparam int DEPTH = 1 << IW;

`ifdef UART_CMD_CSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HEAD, S_TYPE, S_LEN, S_DATA, S_CSUM} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HEAD, S_TYPE, S_LEN, S_DATA} state_t;
`endif

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_type;
   logic [LW-1:0]   r_len;
   logic [IW-1:0]   r_wr_idx;
   logic [IW-1:0]   r_rd_idx;
   logic [7:0]      r_buf [0:DEPTH-1];

   logic            r_cmd_ready, r_pld_ready, r_tx_valid, r_busy, r_done, r_err;
   logic [7:0]      r_tx_data;
   logic            w_cmd_ready_nxt, w_pld_ready_nxt, w_tx_valid_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
   logic [7:0]      w_tx_data_nxt;

   logic            w_cmd_acc, w_pld_acc, w_tx_acc, w_len_bad, w_wr_last, w_rd_last;
   logic [LW-1:0]   w_last_idx;
   logic [IW-1:0]   w_rd_inc;

   assign w_cmd_acc  = i_cmd_valid & r_cmd_ready;
   assign w_pld_acc  = i_pld_valid & r_pld_ready;
   assign w_tx_acc   = r_tx_valid & i_tx_ready;
   assign w_len_bad  = (i_cmd_len == '0) || (i_cmd_len > LW'(P_MAX_LEN));
   assign w_last_idx = r_len - LW'(1);
   assign w_wr_last  = (LW'(r_wr_idx) == w_last_idx);
   assign w_rd_last  = (LW'(r_rd_idx) == w_last_idx);
   assign w_rd_inc   = r_rd_idx + IW'(1);

`ifdef UART_CMD_CSUM_EN
   logic [7:0] r_csum;
   logic [7:0] w_csum_add;
   assign w_csum_add = r_csum + r_tx_data;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_tx_data_nxt = r_tx_data;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_acc) begin
               if (w_len_bad) w_err_nxt = 1'b1;
               else           w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_pld_acc && w_wr_last) begin
               w_state_nxt   = S_HEAD;
               w_tx_data_nxt = P_HEAD;
            end
         end
         S_HEAD: begin
            if (w_tx_acc) begin
               w_state_nxt   = S_TYPE;
               w_tx_data_nxt = r_type;
            end
         end
         S_TYPE: begin
            if (w_tx_acc) begin
               w_state_nxt   = S_LEN;
               w_tx_data_nxt = 8'(r_len);
            end
         end
         S_LEN: begin
            if (w_tx_acc) begin
               w_state_nxt   = S_DATA;
               w_tx_data_nxt = r_buf[{IW{1'b0}}];
            end
         end
         S_DATA: begin
            if (w_tx_acc) begin
               if (w_rd_last) begin
`ifdef UART_CMD_CSUM_EN
                  w_state_nxt   = S_CSUM;
                  w_tx_data_nxt = w_csum_add;
`else
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
`endif
               end else begin
                  w_tx_data_nxt = r_buf[w_rd_inc];
               end
            end
         end
`ifdef UART_CMD_CSUM_EN
         S_CSUM: begin
            if (w_tx_acc) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
      // Outputs are registered images of the next state, so they change exactly on the transition edge.
      w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && !w_err_nxt;
      w_pld_ready_nxt = (w_state_nxt == S_LOAD);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      w_tx_valid_nxt  = w_busy_nxt && (w_state_nxt != S_LOAD);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_type      <= '0;
         r_len       <= '0;
         r_wr_idx    <= '0;
         r_rd_idx    <= '0;
         r_cmd_ready <= 1'b0;
         r_pld_ready <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_pld_ready <= w_pld_ready_nxt;
         r_tx_valid  <= w_tx_valid_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         if (w_cmd_acc) begin
            r_type   <= i_cmd_type;
            r_len    <= i_cmd_len;
            r_wr_idx <= '0;
         end
         if (w_pld_acc) r_wr_idx <= r_wr_idx + IW'(1);
         if (w_tx_acc && r_state == S_LEN)       r_rd_idx <= '0;
         else if (w_tx_acc && r_state == S_DATA) r_rd_idx <= w_rd_inc;
      end
   end

`ifdef UART_CMD_CSUM_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_csum <= '0;
      end else if (w_cmd_acc) begin
         r_csum <= '0;
      end else if (w_tx_acc && (r_state == S_TYPE || r_state == S_LEN || r_state == S_DATA)) begin
         r_csum <= w_csum_add;
      end
   end
`endif

   // Payload storage needs no reset: it is always rewritten before it is read.
   always_ff @(posedge i_clk) begin
      if (w_pld_acc) r_buf[r_wr_idx] <= i_pld_data;
   end

   assign o_cmd_ready = r_cmd_ready;
   assign o_pld_ready = r_pld_ready;
   assign o_tx_data   = r_tx_data;
   assign o_tx_valid  = r_tx_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Bench for uart_cmd_frame_tx: table vectors, hand sequences (back-to-back, mid-frame reset)
// and random frames, all compared against a frame model built from head/type/len/payload rules.

module tb_uart_cmd_frame_tx;

   localparam int LW = 5;

   logic          i_clk;
   logic          i_rst;
   logic [7:0]    i_cmd_type;
   logic [LW-1:0] i_cmd_len;
   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic [7:0]    i_pld_data;
   logic          i_pld_valid;
   logic          o_pld_ready;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   uart_cmd_frame_tx #(.P_MAX_LEN(16), .P_HEAD(8'h55)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_cmd_type(i_cmd_type), .i_cmd_len(i_cmd_len), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_pld_data(i_pld_data), .i_pld_valid(i_pld_valid), .o_pld_ready(o_pld_ready),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]    typ;
      logic [LW-1:0] len;
      logic [7:0]    pld [16];
      int            mode;
      logic          exp_err;
      logic [7:0]    exp_csum;
   } vec_t;

   vec_t       vecs [7];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   logic [7:0]    cur_typ;
   logic [LW-1:0] cur_len;
   logic [7:0]    cur_pld [16];
   int            cur_mode;
   logic          cur_err;
   logic          cur_csum_known;
   logic [7:0]    cur_csum;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference frame: head, type, len, payload, then the mod-256 sum when checksums are built in.
   task automatic build_exp();
      int sum;
      exp_q.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(cur_typ);
      exp_q.push_back(8'(cur_len));
      sum = int'(cur_typ) + int'(cur_len);
      for (int i = 0; i < int'(cur_len); i++) begin
         exp_q.push_back(cur_pld[i]);
         sum += int'(cur_pld[i]);
      end
`ifdef UART_CMD_CSUM_EN
      exp_q.push_back(8'(sum % 256));
`endif
   endtask

   task automatic compare_frame(input string tag);
      build_exp();
      check({tag, "_frame_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_byte"}, got_q[i], exp_q[i]);
`ifdef UART_CMD_CSUM_EN
      if (cur_csum_known && got_q.size() > 0) check({tag, "_csum_const"}, got_q[got_q.size()-1], cur_csum);
`endif
   endtask

   // driver tasks: all start and end at a falling edge; sampling precedes driving.
   task automatic send_cmd(output bit ok);
      ok = 1'b0;
      i_cmd_type  = cur_typ;
      i_cmd_len   = cur_len;
      i_cmd_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (o_cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      if (ok) @(negedge i_clk);
      else check("cmd_accept_timeout", 0, 1);
      i_cmd_valid = 1'b0;
   endtask

   task automatic load_pld(output bit ok);
      bit acc;
      ok = 1'b1;
      for (int i = 0; i < int'(cur_len); i++) begin
         repeat ($urandom_range(0, 1)) begin
            i_pld_valid = 1'b0;
            @(negedge i_clk);
         end
         i_pld_valid = 1'b1;
         i_pld_data  = cur_pld[i];
         acc = 1'b0;
         for (int t = 0; t < 32; t++) begin
            if (o_pld_ready) begin
               acc = 1'b1;
               break;
            end
            @(negedge i_clk);
         end
         @(negedge i_clk);
         if (!acc) begin
            check("pld_accept_timeout", 0, 1);
            ok = 1'b0;
            break;
         end
      end
      i_pld_valid = 1'b0;
      if (ok) begin
         check("head_valid_latency", o_tx_valid, 1);
         check("head_data", o_tx_data, 8'h55);
      end
   endtask

   task automatic collect(input int mode, output bit ok);
      bit         rdy_t = 1'b0;
      bit         prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      int         last_acc = -10;
      int         gaps = 0;
      ok = 1'b0;
      got_q.delete();
      for (int i = 0; i < 400; i++) begin
         if (o_done) begin
            ok = 1'b1;
            break;
         end
         if (prev_stall) begin
            check("stall_valid_held", o_tx_valid, 1);
            check("stall_data_held", o_tx_data, prev_data);
         end
         check("pld_ready_while_tx", o_pld_ready, 0);
         if (!o_tx_valid) gaps++;
         case (mode)
            0:       i_tx_ready = 1'b1;
            1:       begin i_tx_ready = rdy_t; rdy_t = ~rdy_t; end
            default: i_tx_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (o_tx_valid && i_tx_ready) begin
            got_q.push_back(o_tx_data);
            last_acc = cyc;
         end
         prev_stall = o_tx_valid && !i_tx_ready;
         prev_data  = o_tx_data;
         // payload offered outside LOAD must be ignored
         i_pld_valid = ($urandom_range(0, 1) == 1);
         i_pld_data  = 8'($urandom);
         @(negedge i_clk);
      end
      i_pld_valid = 1'b0;
      if (ok) begin
         check("done_latency", cyc - last_acc, 1);
         check("done_busy_low", o_busy, 0);
         check("done_cmd_ready", o_cmd_ready, 1);
         check("done_tx_valid_low", o_tx_valid, 0);
         if (mode == 0) check("no_gap", gaps, 0);
      end else begin
         check("done_timeout", 0, 1);
      end
   endtask

   task automatic run_frame(input string tag);
      bit ok;
      send_cmd(ok);
      if (!ok) return;
      if (cur_err) begin
         check({tag, "_err_pulse"}, o_err, 1);
         check({tag, "_err_cmd_ready"}, o_cmd_ready, 0);
         check({tag, "_err_tx_valid"}, o_tx_valid, 0);
         check({tag, "_err_busy"}, o_busy, 0);
         @(negedge i_clk);
         check({tag, "_err_clear"}, o_err, 0);
         check({tag, "_err_cmd_ready_back"}, o_cmd_ready, 1);
         check({tag, "_err_tx_valid2"}, o_tx_valid, 0);
      end else begin
         check({tag, "_no_err"}, o_err, 0);
         check({tag, "_pld_ready_n1"}, o_pld_ready, 1);
         load_pld(ok);
         if (!ok) return;
         collect(cur_mode, ok);
         compare_frame(tag);
      end
   endtask

   task automatic set_cur(input logic [7:0] typ, input logic [LW-1:0] len, input int mode);
      cur_typ        = typ;
      cur_len        = len;
      cur_mode       = mode;
      cur_err        = (len == 0) || (len > 16);
      cur_csum_known = 1'b0;
      cur_csum       = '0;
   endtask

   initial begin
      bit  ok;
      bit  found;
      int  n;
      i_rst = 1'b0; i_cmd_type = '0; i_cmd_len = '0; i_cmd_valid = 1'b0;
      i_pld_data = '0; i_pld_valid = 1'b0; i_tx_ready = 1'b0;
      #1 i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      check("rst_cmd_ready", o_cmd_ready, 0);
      check("rst_pld_ready", o_pld_ready, 0);
      check("rst_tx_valid", o_tx_valid, 0);
      check("rst_tx_data", o_tx_data, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      i_rst = 1'b0;
      check("cmd_ready_before_edge", o_cmd_ready, 0);
      @(negedge i_clk);
      check("cmd_ready_after_rst", o_cmd_ready, 1);

      // stimulus table
      foreach (vecs[v]) for (int k = 0; k < 16; k++) vecs[v].pld[k] = '0;
      vecs[0].typ = 8'h01; vecs[0].len = 1;  vecs[0].pld[0] = 8'h08; vecs[0].mode = 0; vecs[0].exp_err = 0; vecs[0].exp_csum = 8'h0A;
      vecs[1].typ = 8'h05; vecs[1].len = 1;  vecs[1].pld[0] = 8'h01; vecs[1].mode = 0; vecs[1].exp_err = 0; vecs[1].exp_csum = 8'h07;
      vecs[2].typ = 8'h02; vecs[2].len = 16; vecs[2].mode = 1; vecs[2].exp_err = 0; vecs[2].exp_csum = 8'h8A;
      for (int k = 0; k < 16; k++) vecs[2].pld[k] = 8'(k);
      vecs[3].typ = 8'h07; vecs[3].len = 0;  vecs[3].mode = 0; vecs[3].exp_err = 1; vecs[3].exp_csum = 8'h00;
      vecs[4].typ = 8'h07; vecs[4].len = 17; vecs[4].mode = 0; vecs[4].exp_err = 1; vecs[4].exp_csum = 8'h00;
      vecs[5].typ = 8'h3C; vecs[5].len = 5;  vecs[5].mode = 2; vecs[5].exp_err = 0; vecs[5].exp_csum = 8'h6B;
      for (int k = 0; k < 5; k++) vecs[5].pld[k] = 8'(8'hA0 + k);
      vecs[6].typ = 8'hFF; vecs[6].len = 2;  vecs[6].pld[0] = 8'hFF; vecs[6].pld[1] = 8'hFF;
      vecs[6].mode = 1; vecs[6].exp_err = 0; vecs[6].exp_csum = 8'hFF;

      foreach (vecs[v]) begin
         set_cur(vecs[v].typ, vecs[v].len, vecs[v].mode);
         for (int k = 0; k < 16; k++) cur_pld[k] = vecs[v].pld[k];
         cur_err        = vecs[v].exp_err;
         cur_csum_known = 1'b1;
         cur_csum       = vecs[v].exp_csum;
         run_frame($sformatf("vec%0d", v));
      end

      // back-to-back: second descriptor held while the first frame drains
      set_cur(8'h03, 2, 0);
      cur_pld[0] = 8'hAA; cur_pld[1] = 8'hBB;
      send_cmd(ok);
      check("b2b1_pld_ready", o_pld_ready, 1);
      load_pld(ok);
      i_cmd_type = 8'h04; i_cmd_len = 3; i_cmd_valid = 1'b1;
      collect(0, ok);
      compare_frame("b2b1");
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      check("b2b2_accept_on_done", o_pld_ready, 1);
      check("b2b2_busy", o_busy, 1);
      set_cur(8'h04, 3, 0);
      cur_pld[0] = 8'h11; cur_pld[1] = 8'h22; cur_pld[2] = 8'h33;
      load_pld(ok);
      collect(0, ok);
      compare_frame("b2b2");

      // reset while DATA byte 3 is on the bus
      set_cur(8'h02, 8, 0);
      for (int k = 0; k < 8; k++) cur_pld[k] = 8'(8'h10 + k);
      send_cmd(ok);
      load_pld(ok);
      i_tx_ready = 1'b1;
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (o_tx_valid && n == 6) begin
            found = 1'b1;
            break;
         end
         if (o_tx_valid) n++;
         @(negedge i_clk);
      end
      check("rst_mid_reached_b3", found, 1);
      check("rst_mid_b3_data", o_tx_data, 8'h13);
      #2 i_rst = 1'b1;
      #1;
      check("rst_mid_tx_valid", o_tx_valid, 0);
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_pld_ready", o_pld_ready, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_mid_cmd_ready_pre", o_cmd_ready, 0);
      @(negedge i_clk);
      check("rst_mid_cmd_ready", o_cmd_ready, 1);
      set_cur(8'h05, 1, 0);
      cur_pld[0] = 8'h01;
      run_frame("after_rst");

      // randomized frames against the model
      for (int r = 0; r < 24; r++) begin
         set_cur(8'($urandom), LW'($urandom_range(0, 18)), $urandom_range(0, 2));
         for (int k = 0; k < 16; k++) cur_pld[k] = 8'($urandom);
         run_frame($sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
